// File: rtl/trace_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trace_capture_pkg
//  Description : Shared types and default constants for the trace capture
//                block. Holds the FSM state enum with its explicit 3-bit
//                encoding and the default sizing parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package trace_capture_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DEPTH    = 32;
    localparam int STATE_W      = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_READ  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/trace_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : trace_capture_if
//  Description : Readout handshake between the trace capture block and its
//                consumer.
//  Signals     : rd_valid - read data available (producer)
//                rd_ready - consumer accepts rd_data (consumer)
//                rd_data  - oldest unread sample (producer)
//  Modports    : master - producer side (trace_capture)
//                slave  - consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface trace_capture_if
    import trace_capture_pkg::*;
#(
    parameter int DATA_W = DEF_WIDTH * DEF_CHANNELS
);
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ============================================================================
//  Module      : trace_ram
//  Description : Single-clock simple dual-port memory, DEPTH x DATA_W, with a
//                registered read port. Contents are never reset.
//  Ports       : clk   - clock
//                we    - write enable
//                waddr - write address
//                wdata - write data
//                raddr - read address (data appears one cycle later)
//                rdata - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_ram #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        rdata <= r_mem[raddr];
    end
endmodule
`default_nettype wire

// File: rtl/trace_capture.sv
`default_nettype none
// ============================================================================
//  Module      : trace_capture
//  Description : Logic-analyser style trace buffer. After arm, samples are
//                written into a circular buffer until a trigger, then
//                post_count further samples are stored and the captured
//                window is streamed out oldest-first over a valid/ready port.
//  Ports       : Clk, Reset_n     - clock, asynchronous active-low reset
//                probe            - CHANNELS*WIDTH probe word, ch0 in LSBs
//                sample_en        - probe is a valid sample this cycle
//                arm              - pulse that starts/restarts a capture
//                trig             - external level trigger
//                post_count       - post-trigger samples, latched on arm
//                rd (master)      - rd_valid / rd_ready / rd_data readout
//                state_o          - current FSM state encoding
//                trig_pos         - trigger sample index in readout order
//  Options     : TRACE_CAPTURE_MATCH_EN adds match_val/match_mask inputs and
//                a channel-0 masked-compare trigger ORed with trig.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic [CHANNELS*WIDTH-1:0]   probe,
    input  logic                        sample_en,
    input  logic                        arm,
    input  logic                        trig,
    input  logic [$clog2(DEPTH)-1:0]    post_count,
`ifdef TRACE_CAPTURE_MATCH_EN
    input  logic [WIDTH-1:0]            match_val,
    input  logic [WIDTH-1:0]            match_mask,
`endif
    trace_capture_if.master             rd,
    output logic [STATE_W-1:0]          state_o,
    output logic [$clog2(DEPTH)-1:0]    trig_pos
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;          // fill must be able to hold DEPTH
    localparam int DW = CHANNELS * WIDTH;
    localparam logic [FW-1:0] C_FULL = FW'(DEPTH);

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr, r_post, r_post_left;
    logic [FW-1:0]   r_fill, r_rd_left;
    logic            r_rd_valid;
    logic            w_restart, w_wr_en, w_enter_post, w_pop, w_trig;
    logic [AW-1:0]   w_rd_start, w_rd_addr;
    logic [DW-1:0]   w_ram_q;

`ifdef TRACE_CAPTURE_MATCH_EN
    logic w_match;
    assign w_match = (((probe[WIDTH-1:0] ^ match_val) & match_mask) == '0);
    assign w_trig  = trig | w_match;
`else
    assign w_trig  = trig;
`endif

    assign w_pop = r_rd_valid & rd.rd_ready;

    // Oldest stored sample. When the buffer is full fill[AW-1:0] is zero,
    // so the window starts at the write pointer itself.
    assign w_rd_start = r_wr_ptr - r_fill[AW-1:0];

    // The RAM address always points one step ahead of the registered read
    // pointer update, so the registered RAM output tracks mem[r_rd_ptr]
    // and holds steady while the consumer stalls.
    assign w_rd_addr = (r_state == ST_DONE) ? w_rd_start :
                       (w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_restart    = 1'b0;
        w_wr_en      = 1'b0;
        w_enter_post = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arm) begin
                    w_restart   = 1'b1;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (arm) begin
                    w_restart   = 1'b1;
                end else if (sample_en) begin
                    w_wr_en = 1'b1;
                    if (w_trig) begin
                        if (r_post == '0) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_enter_post = 1'b1;
                            w_state_nxt  = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (arm) begin
                    w_restart   = 1'b1;
                    w_state_nxt = ST_ARMED;
                end else if (sample_en) begin
                    w_wr_en = 1'b1;
                    if (r_post_left == AW'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_READ;
            end
            ST_READ: begin
                if (w_pop && r_rd_left == FW'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_post      <= '0;
            r_post_left <= '0;
            r_rd_ptr    <= '0;
            r_rd_left   <= '0;
            r_rd_valid  <= 1'b0;
            trig_pos    <= '0;
        end else begin
            if (w_restart) begin
                r_wr_ptr <= '0;
                r_fill   <= '0;
                r_post   <= post_count;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (r_fill != C_FULL) begin
                    r_fill <= r_fill + FW'(1);
                end
            end

            if (w_enter_post) begin
                r_post_left <= r_post;
            end else if (r_state == ST_POST && w_wr_en) begin
                r_post_left <= r_post_left - AW'(1);
            end

            if (r_state == ST_DONE) begin
                // Everything stored ahead of the post-trigger tail and the
                // trigger sample itself precedes the trigger in readout.
                r_rd_ptr   <= w_rd_start;
                r_rd_left  <= r_fill;
                r_rd_valid <= 1'b1;
                trig_pos   <= AW'(r_fill - FW'(1) - FW'(r_post));
            end else if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_left <= r_rd_left - FW'(1);
                if (r_rd_left == FW'(1)) begin
                    r_rd_valid <= 1'b0;
                end
            end
        end
    end

    trace_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DW)
    ) u_ram (
        .clk   (Clk),
        .we    (w_wr_en),
        .waddr (r_wr_ptr),
        .wdata (probe),
        .raddr (w_rd_addr),
        .rdata (w_ram_q)
    );

    // RAM output register cannot be reset; gate it so rd_data reads zero
    // whenever nothing valid is being presented.
    assign rd.rd_valid = r_rd_valid;
    assign rd.rd_data  = r_rd_valid ? w_ram_q : '0;
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter WIDTH, default 16, bit width of one probe channel.
REQ-002 Parameter CHANNELS, default 4, number of probe channels captured per sample.
REQ-003 Parameter DEPTH, default 32, sample entries in the buffer; power of two, at least 4.
REQ-004 Port Clk  input  1  sole clock; all state changes on rising edge.
REQ-005 Port Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port probe  input  CHANNELS*WIDTH  probe words; channel 0 in the LSBs.
REQ-007 Port sample_en  input  1  qualifies probe as a valid sample this cycle.
REQ-008 Port arm  input  1  single-cycle pulse that starts a capture.
REQ-009 Port trig  input  1  external trigger, level-sampled.
REQ-010 Port post_count  input  $clog2(DEPTH)  post-trigger samples, latched on arm.
REQ-011 Port rd_valid  output  1  read data available.
REQ-012 Port rd_ready  input  1  consumer accepts rd_data.
REQ-013 Port rd_data  output  CHANNELS*WIDTH  oldest unread sample.
REQ-014 Port state_o  output  3  current FSM state encoding.
REQ-015 Port trig_pos  output  $clog2(DEPTH)  index of the trigger sample in readout order.

Function
REQ-016 FSM states SHALL be IDLE, ARMED, POST, DONE and READ, with encodings 0 to 4.
REQ-017 IDLE -> ARMED on arm: clear wr_ptr and fill count, and latch post_count.
REQ-018 In ARMED, each sample_en cycle SHALL write probe at wr_ptr, wrap wr_ptr modulo DEPTH, and saturate fill at DEPTH.
REQ-019 ARMED -> POST on the first sample_en cycle with a trigger asserted; that sample is stored and its address recorded.
REQ-020 Trigger with fill below DEPTH-post_count-1 SHALL still be accepted; trig_pos equals the actual pre-trigger count.
REQ-021 POST: each sample_en cycle SHALL store one sample; after post_count samples, go to DONE.
REQ-022 post_count=0: go ARMED -> DONE directly on the trigger sample.
REQ-023 DONE -> READ next cycle; read pointer = wr_ptr minus stored count, modulo DEPTH.
REQ-024 READ: rd_valid high while unread samples remain.
REQ-025 A rd_valid and rd_ready cycle SHALL advance the read pointer with wrap.
REQ-026 rd_data SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-027 READ -> IDLE on the cycle the last sample is accepted.
REQ-028 arm in ARMED or POST SHALL restart the capture, with the same effect as REQ-017.
REQ-029 arm in DONE or READ SHALL be ignored.
REQ-030 Buffer reads SHALL be registered; rd_data is valid the cycle rd_valid rises, with one cycle of prefetch latency allowed after DONE.

Reset
REQ-031 Reset_n low SHALL asynchronously force: state IDLE, all pointers and counts 0, rd_valid 0, rd_data 0, trig_pos 0.
REQ-032 Reset SHALL NOT clear buffer contents.
REQ-033 Reset mid-capture or mid-read SHALL abort cleanly with no spurious rd_valid after release.

Configuration
REQ-034 With TRACE_CAPTURE_MATCH_EN defined, add input match_val (WIDTH bits) and input match_mask (WIDTH bits).
REQ-035 With TRACE_CAPTURE_MATCH_EN defined, the effective trigger SHALL be trig OR (((probe channel 0 XOR match_val) AND match_mask) == 0).
REQ-036 Without TRACE_CAPTURE_MATCH_EN, those ports and the comparator SHALL be absent; the trigger is trig only.

Structure
REQ-037 Package trace_capture_pkg SHALL hold the state enum, its 3-bit encoding and the default parameter constants.
REQ-038 Storage SHALL be one sub-module trace_ram: a single-clock simple dual-port memory, DEPTH x CHANNELS*WIDTH, with a registered read port.

Verification
REQ-039 Bench SHALL cover: arm, 40 samples with probe=n, trig on sample 20, post_count=5 -> 26 words read, 0 through 25, trig_pos=20.
REQ-040 Bench SHALL cover: arm, 100 samples, trig on sample 90, post_count=8 -> 32 words read, 67 through 98, trig_pos=23 (wrap).
REQ-041 Bench SHALL cover: trig asserted on the first sample after arm, post_count=0 -> exactly one word read, trig_pos=0.
REQ-042 Bench SHALL cover: rd_ready low for 5 cycles mid-read -> rd_data held constant and no word lost or duplicated.
REQ-043 Bench SHALL cover: Reset_n pulsed low during POST -> state_o=0 immediately and rd_valid=0 after release.
REQ-044 Bench SHALL cover, with TRACE_CAPTURE_MATCH_EN defined: match_val=16'h3000, match_mask=16'hF000, trig=0 -> trigger fires on the first channel-0 value 16'h3xxx.
